// File: rtl/pixel_row_packer.sv
// Packs a serial binary pixel stream into 16-bit row words via an external 1-to-16 demux,
// handing each row downstream over valid/ready and tracking the row index within a frame.
module pixel_row_packer #(
  parameter int COLS = 16,
  parameter int ROWS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_start_i,
  input  logic                      pix_in_i,
  input  logic                      pix_valid_i,
  output logic                      pix_ready_o,
  output logic                      demux_in_o,
  output logic [$clog2(COLS)-1:0]   demux_sel_o,
  input  logic [COLS-1:0]           demux_out_i,
  output logic [COLS-1:0]           row_out_o,
  output logic                      row_valid_o,
  input  logic                      row_ready_i,
  output logic [$clog2(ROWS)-1:0]   row_idx_o,
  output logic                      frame_done_o
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic {FILL, HOLD} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [COLS-1:0] acc_q, acc_d;
  logic [COLS-1:0] row_out_q, row_out_d;
  logic            row_valid_q, row_valid_d;
  logic            frame_done_q, frame_done_d;
  logic            pix_accept;

  assign pix_ready_o  = (state_q == FILL) && !frame_start_i;
  assign pix_accept   = pix_valid_i && pix_ready_o;
  assign demux_in_o   = pix_in_i && pix_accept;
  assign demux_sel_o  = col_q;
  assign row_out_o    = row_out_q;
  assign row_valid_o  = row_valid_q;
  assign row_idx_o    = row_q;
  assign frame_done_o = frame_done_q;

  always_comb begin
    // NOTE: every target gets a default before any branch, so no path leaves a value unassigned and no latch is inferred.
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    acc_d        = acc_q;
    row_out_d    = row_out_q;
    row_valid_d  = row_valid_q;
    frame_done_d = 1'b0;

    if (frame_start_i) begin
      // Frame restart wins over everything: partial row and any held row are dropped.
      state_d     = FILL;
      col_d       = '0;
      row_d       = '0;
      acc_d       = '0;
      row_valid_d = 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (pix_accept) begin
            if (col_q == LAST_COL) begin
              row_out_d   = acc_q | demux_out_i;
              acc_d       = '0;
              col_d       = '0;
              row_valid_d = 1'b1;
              state_d     = HOLD;
            end else begin
              acc_d = acc_q | demux_out_i;
              col_d = col_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (row_ready_i) begin
            row_valid_d = 1'b0;
            state_d     = FILL;
            if (row_q == LAST_ROW) begin
              row_d        = '0;
              frame_done_d = 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL;
      col_q        <= '0;
      row_q        <= '0;
      acc_q        <= '0;
      row_out_q    <= '0;
      row_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      acc_q        <= acc_d;
      row_out_q    <= row_out_d;
      row_valid_q  <= row_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: doc/pixel_row_packer.md
# pixel_row_packer

Upstream stage that feeds the 1-to-16 one-bit demultiplexer. It accepts a serial stream of binary pixels from the thresholding front end and drives the demux `in`/`sel` inputs with the pixel value and its column position. It OR-accumulates the demux's one-hot output into a 16-bit row word. Each completed row is handed to the feature-extraction stage over a valid/ready handshake, and the block tracks the row index within a 16×16 character frame.

## Interface
- `COLS`, 16: pixels per row; fixed by the 16-bit demux output width.
- `ROWS`, 16: rows per frame; sets `row_idx` wrap and `frame_done`.

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `frame_start`  in  1  synchronous clear of column/row counters and accumulator.
- `pix_in`  in  1  binary pixel (1 = ink).
- `pix_valid`  in  1  `pix_in` is valid this cycle.
- `pix_ready`  out  1  block can accept a pixel this cycle.
- `demux_in`  out  1  to demux `in`.
- `demux_sel`  out  4  to demux `sel`; current column.
- `demux_out`  in  16  from demux `out`; one-hot or zero.
- `row_out`  out  16  packed row; bit k = column k.
- `row_valid`  out  1  `row_out` / `row_idx` valid.
- `row_ready`  in  1  downstream accepts the row.
- `row_idx`  out  4  index of the row on `row_out`, 0..ROWS-1.
- `frame_done`  out  1  one-cycle pulse after the last row of the frame is accepted.

## Operation
- Registers: `col[3:0]`, `row[3:0]`, `acc[15:0]`, `row_out`, `state` ∈ {FILL, HOLD}.
- `pix_ready = (state == FILL) && !frame_start`.
- A pixel is accepted when `pix_valid && pix_ready`.
- `demux_in = pix_in && pixel accepted`; `demux_sel = col`. Both are combinational.
- FILL, pixel accepted, `col < 15`:
  - `acc <= acc | demux_out`
  - `col <= col + 1`
- FILL, pixel accepted, `col == 15`:
  - `row_out <= acc | demux_out`
  - `acc <= 0`, `col <= 0`
  - `row_valid <= 1`, state → HOLD
- HOLD: `row_out` and `row_idx` are held stable while `row_valid && !row_ready`.
- HOLD, `row_ready`:
  - `row_valid <= 0`, state → FILL
  - If `row == ROWS-1`: `row <= 0` and `frame_done <= 1` for one cycle; otherwise `row <= row + 1`.
- `row_idx = row`.
- `frame_start` takes priority over every other event:
  - Clears `col`, `row`, `acc`, `row_valid`; state → FILL.
  - A pixel presented in the same cycle is not accepted (`pix_ready` = 0).
  - A row on `row_out` is dropped, including when `row_ready` is high in the same cycle.
  - No `frame_done` is produced.
- Zero pixels (`pix_in` = 0) still advance `col`. The demux output is zero for them, so `acc` is unchanged.
- `demux_out` is trusted. A non-one-hot value is ORed in as is; no checking.

## Timing
- Reset values:
  - `state` = FILL, `col` = `row` = `acc` = 0.
  - `row_out` = 0, `row_valid` = 0, `frame_done` = 0.
  - `pix_ready` = 1, `demux_in` = 0, `demux_sel` = 0.
- Latency: `row_valid` rises the cycle after the 16th pixel of a row is accepted.
- HOLD lasts at least one cycle. Peak throughput is 16 pixels per 17 cycles with `row_ready` held high.
- `frame_done` rises the cycle after the 16th row handshake. It coincides with `pix_ready` = 1 for the next frame's first pixel.
- Async `rst` mid-row or mid-HOLD discards all partial data immediately. No output glitches after deassertion; the first edge after deassertion starts in FILL.
- `pix_valid` with `pix_ready` low: the pixel is not consumed. The source holds it until it is accepted.

## Test plan
- Reset, then 16 pixels 1,0,1,0,... back-to-back with `row_ready` = 1:
  - `row_out` = 16'h5555 (bit0 = 1), `row_valid` high exactly one cycle, `row_idx` = 0.
  - `pix_ready` = 0 during that cycle.
- Row of all ones with `row_ready` held low for 5 cycles:
  - `row_out` = 16'hFFFF held stable, `pix_ready` = 0 throughout.
  - Release `row_ready` → handshake, `row_idx` advances to 1.
- Full frame of 256 pixels with random `pix_valid` gaps:
  - 16 rows with `row_idx` 0..15.
  - `frame_done` pulses once, one cycle after the row-15 handshake.
  - Next frame starts at `row_idx` 0.
- Single pixel 1 at column 15 only:
  - `row_out` = 16'h8000.
  - `demux_sel` = 15 and `demux_in` = 1 on that acceptance cycle only.
- `frame_start` after 7 pixels, asserted together with a valid pixel:
  - That pixel is not accepted; `col` returns to 0.
  - The next 16 pixels of 1 give `row_out` = 16'hFFFF with `row_idx` = 0.
- Async `rst` pulse in HOLD with `row_valid` = 1:
  - `row_valid` = 0 immediately, all outputs at reset values.
  - Subsequent row packs correctly.
